// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-granular arbiter sharing one UART TX FIFO write port
// among four byte-stream requesters, with a stall timeout that revokes the grant.
module uart_tx_arbiter #(
    parameter int DBIT    = 8,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          req,
    input  logic [4*DBIT-1:0]   din,
    input  logic [3:0]          last,
    output logic [3:0]          ack,
    input  logic                tx_full,
    output logic                wr_uart,
    output logic [DBIT-1:0]     w_data,
    output logic [1:0]          grant,
    output logic                busy,
    output logic                abort
);

    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [TW-1:0] CNT_MAX = TW'(TIMEOUT - 1);

    state_t          state, state_n;
    logic [1:0]      grant_n;
    logic [1:0]      last_g, last_g_n;
    logic [TW-1:0]   cnt, cnt_n;
    logic            abort_n;
    logic [1:0]      pick;
    logic            found;
    logic [DBIT-1:0] bytes [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            bytes[i] = din[i*DBIT +: DBIT];
        end
    end

    // Search starts one past the previous owner so every requester gets a turn.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if (!found && req[2'(last_g + 2'(i))]) begin
                found = 1'b1;
                pick  = 2'(last_g + 2'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            last_g <= 2'd3;
            cnt    <= '0;
            abort  <= 1'b0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            last_g <= last_g_n;
            cnt    <= cnt_n;
            abort  <= abort_n;
        end
    end

    always_comb begin
        state_n  = state;
        grant_n  = grant;
        last_g_n = last_g;
        cnt_n    = cnt;
        abort_n  = 1'b0;
        wr_uart  = 1'b0;
        ack      = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_n = pick;
                    cnt_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                // A cycle with reset asserted never writes, so no partial packet byte escapes.
                wr_uart    = req[grant] & ~tx_full & ~reset;
                ack[grant] = wr_uart;
                if (wr_uart) begin
                    cnt_n = '0;
                    if (last[grant]) begin
                        state_n  = IDLE;
                        last_g_n = grant;
                    end
                end else if (cnt == CNT_MAX) begin
                    state_n  = IDLE;
                    last_g_n = grant;
                    abort_n  = 1'b1;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy   = (state == SEND);
    assign w_data = bytes[grant];

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int DBIT = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req;
    logic [4*DBIT-1:0] din;
    logic [3:0]      last;
    logic [3:0]      ack;
    logic            tx_full;
    logic            wr_uart;
    logic [DBIT-1:0] w_data;
    logic [1:0]      grant;
    logic            busy;
    logic            abort;

    int errors = 0;
    int checks = 0;
    int seq [4];
    int order [5] = '{0, 1, 2, 3, 0};

    uart_tx_arbiter #(.DBIT(DBIT), .TIMEOUT(8), .TW(4)) dut (
        .clk(clk), .reset(reset), .req(req), .din(din), .last(last), .ack(ack),
        .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data), .grant(grant),
        .busy(busy), .abort(abort)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic set_byte(input int i, input logic [7:0] b);
        din[i*DBIT +: DBIT] = b;
    endtask

    task automatic chk_wr(input string tag, input int g, input logic [7:0] b);
        chk({tag, "_wr"},    32'(wr_uart), 32'd1);
        chk({tag, "_data"},  32'(w_data),  32'(b));
        chk({tag, "_ack"},   32'(ack),     32'(1 << g));
        chk({tag, "_grant"}, 32'(grant),   32'(g));
        chk({tag, "_busy"},  32'(busy),    32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(busy),    32'd0);
        chk({tag, "_wr"},   32'(wr_uart), 32'd0);
        chk({tag, "_ack"},  32'(ack),     32'd0);
    endtask

    task automatic drive_rr;
        for (int i = 0; i < 4; i++) begin
            set_byte(i, 8'(16 * i + seq[i]));
            last[i] = seq[i][0];
        end
    endtask

    initial begin
        reset = 1'b1; req = '0; din = '0; last = '0; tx_full = 1'b0;
        tick; tick;
        reset = 1'b0;
        sample;
        chk_idle("rst");
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);

        // single packet from requester 2
        tick; req = 4'b0100; set_byte(2, 8'h41);
        sample; chk_idle("sp_c0");
        tick; sample; chk_wr("sp_c1", 2, 8'h41);
        tick; set_byte(2, 8'h42); sample; chk_wr("sp_c2", 2, 8'h42);
        tick; set_byte(2, 8'h43); last = 4'b0100; sample; chk_wr("sp_c3", 2, 8'h43);
        tick; req = '0; last = '0; sample; chk_idle("sp_c4");

        // round robin after a fresh reset: all four hold two-byte packets
        tick; reset = 1'b1; tick; reset = 1'b0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        req = 4'b1111; drive_rr;
        sample; chk_idle("rr_start");
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 2; b++) begin
                tick; drive_rr; sample;
                chk_wr($sformatf("rr_p%0d_b%0d", p, b), order[p], 8'(16 * order[p] + seq[order[p]]));
                seq[order[p]]++;
            end
            tick;
            if (p == 4) req = '0;
            drive_rr; sample;
            chk_idle($sformatf("rr_gap%0d", p));
        end
        last = '0;

        // backpressure on requester 1
        tick; req = 4'b0010; set_byte(1, 8'hA0);
        sample; chk_idle("bp_c0");
        tick; sample; chk_wr("bp_a0", 1, 8'hA0);
        tick; set_byte(1, 8'hA1); tx_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick;
            sample;
            chk($sformatf("bp_full%0d_wr", k),   32'(wr_uart), 32'd0);
            chk($sformatf("bp_full%0d_ack", k),  32'(ack),     32'd0);
            chk($sformatf("bp_full%0d_busy", k), 32'(busy),    32'd1);
        end
        tick; tx_full = 1'b0; sample; chk_wr("bp_a1", 1, 8'hA1);
        tick; set_byte(1, 8'hA2); last = 4'b0010; sample; chk_wr("bp_a2", 1, 8'hA2);
        tick; req = '0; last = '0; sample; chk_idle("bp_end");

        // timeout: requester 3 stalls after one non-last byte, requester 0 waits
        tick; req = 4'b1000; set_byte(3, 8'h77);
        sample; chk_idle("to_c0");
        tick; sample; chk_wr("to_ack", 3, 8'h77);
        tick; req = 4'b0001; set_byte(0, 8'h99); last = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) tick;
            sample;
            chk($sformatf("to_w%0d_busy", k),  32'(busy),  32'd1);
            chk($sformatf("to_w%0d_grant", k), 32'(grant), 32'd3);
            chk($sformatf("to_w%0d_abort", k), 32'(abort), 32'd0);
            chk($sformatf("to_w%0d_ack", k),   32'(ack),   32'd0);
        end
        tick; sample;
        chk("to_abort", 32'(abort), 32'd1);
        chk_idle("to_abort");
        tick; sample; chk_wr("to_next", 0, 8'h99);
        chk("to_abort_once", 32'(abort), 32'd0);
        tick; req = '0; last = '0; sample; chk_idle("to_end");

        // last byte written exactly when the counter is at its limit
        tick; req = 4'b0100; set_byte(2, 8'h55);
        sample; chk_idle("race_c0");
        tick; sample; chk_wr("race_first", 2, 8'h55);
        tick; req = '0;
        for (int k = 2; k <= 8; k++) begin
            if (k > 2) tick;
            sample;
            chk($sformatf("race_w%0d_abort", k), 32'(abort), 32'd0);
            chk($sformatf("race_w%0d_busy", k),  32'(busy),  32'd1);
        end
        tick; req = 4'b0100; set_byte(2, 8'h56); last = 4'b0100;
        sample; chk_wr("race_last", 2, 8'h56);
        chk("race_last_abort", 32'(abort), 32'd0);
        tick; req = '0; last = '0; sample;
        chk_idle("race_end");
        chk("race_end_abort", 32'(abort), 32'd0);

        // requester 0 packet leaves the pointer at 0 before the reset test
        tick; req = 4'b0001; set_byte(0, 8'h0A); last = 4'b0001;
        sample; chk_idle("pre_c0");
        tick; sample; chk_wr("pre_w", 0, 8'h0A);
        tick; req = 4'b0010; last = '0; set_byte(1, 8'h31);
        sample; chk_idle("rs_c0");
        tick; sample; chk_wr("rs_w0", 1, 8'h31);
        tick; set_byte(1, 8'h32); reset = 1'b1;
        sample;
        tick; reset = 1'b0; req = 4'b0011; set_byte(0, 8'h01); last = 4'b0001;
        sample;
        chk_idle("rs_after");
        chk("rs_after_grant", 32'(grant), 32'd0);
        tick; sample; chk_wr("rs_regrant", 0, 8'h01);
        tick; req = '0; last = '0; sample; chk_idle("rs_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
